data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: storage depth in 32-bit words, indexed by req_addr[7:2].
REQ-002 Parameter LATENCY, default 2, legal range 1..15: clock edges from request accept to response valid.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  8  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  CPU accepts response.
REQ-013 resp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or had an illegal funct3.
REQ-015 busy  output  1  high in every state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 In IDLE, req_ready SHALL be 1; in WAIT and RESP it SHALL be 0.
REQ-018 Accept SHALL occur on an edge with req_valid=1 and req_ready=1; that edge latches write, addr, wdata and funct3, loads cnt=LATENCY, and moves the FSM to WAIT.
REQ-019 In WAIT, each edge SHALL decrement cnt; the edge on which cnt==1 SHALL perform the access and move the FSM to RESP.
REQ-020 resp_valid SHALL rise exactly LATENCY edges after the accept edge.
REQ-021 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until an edge with resp_ready=1; that edge returns the FSM to IDLE and clears resp_valid.
REQ-022 A new request SHALL NOT be accepted on the response handshake edge; minimum spacing between accepts is LATENCY+2 cycles.
REQ-023 A request SHALL be an error when:
- funct3 is 011, 110 or 111;
- a halfword access (001, 101) has addr[0]=1;
- a word access (010) has addr[1:0]!=00;
- a store uses funct3 100 or 101.
REQ-024 On error: resp_err=1, resp_rdata=0, memory unchanged.
REQ-025 Store B SHALL write wdata[7:0] into byte lane addr[1:0] only.
REQ-026 Store H SHALL write wdata[15:0] into lanes {addr[1],0} and {addr[1],1} only.
REQ-027 Store W SHALL write the full word.
REQ-028 Load B/H SHALL sign-extend the selected lane(s); BU/HU SHALL zero-extend; W SHALL return the full word.
REQ-029 Byte lane 0 SHALL be bits [7:0] (little-endian).
REQ-030 The memory write SHALL occur only on the WAIT->RESP edge, never at accept.
REQ-031 req_* inputs SHALL be ignored outside the accept edge.
REQ-032 resp_ready SHALL be ignored outside RESP.

Reset
REQ-033 While rst=0, independent of clk, the block SHALL force: FSM=IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, latched request cleared.
REQ-034 After release, req_ready SHALL be 1 (IDLE).
REQ-035 Reset asserted during WAIT SHALL discard the pending store; memory SHALL be unchanged.
REQ-036 Memory array contents SHALL NOT be altered by reset.

Verification
REQ-037 LATENCY=2, store W addr 0x10 wdata 0xDEADBEEF, then load W addr 0x10 -> resp_valid 2 edges after each accept; load rdata=0xDEADBEEF, err=0.
REQ-038 Store B addr 0x11 wdata 0x80 over word 0xDEADBEEF -> word becomes 0xDEAD80EF; LB 0x11 returns 0xFFFFFF80; LBU 0x11 returns 0x00000080; LHU 0x12 returns 0x0000DEAD.
REQ-039 LW addr 0x06 and SH addr 0x13 -> resp_err=1, rdata=0; a following LW of that word shows it unchanged.
REQ-040 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata stable, req_ready=0 throughout; resp_ready=1 -> IDLE on the next edge, req_ready=1.
REQ-041 Assert rst=0 one cycle after accepting SW addr 0x20 wdata 0x12345678 -> outputs clear immediately; after release, LW 0x20 returns the prior contents.
REQ-042 LATENCY=1, req_valid held high continuously -> accepts exactly every 3 cycles with resp_ready=1.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-port data memory responder for an RV32I load/store unit.
// Accepts one request at a time, answers after LATENCY edges, and holds the response until taken.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic          access;
    logic          req_err;
    logic [AW-1:0] word_idx;
    logic [3:0]    lane_we;
    logic [31:0]   lane_wdata;
    logic [31:0]   rd_word;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   load_data;

    // The access edge is the last WAIT edge; a zero count is treated the same so WAIT can never stall.
    assign access   = (state_q == S_WAIT) && (cnt_q <= 4'd1);
    assign word_idx = addr_q[AW+1:2];

    always_comb begin
        req_err = 1'b0;
        case (funct3_q)
            F3_B, F3_BU: req_err = 1'b0;
            F3_H, F3_HU: req_err = addr_q[0];
            F3_W:        req_err = (addr_q[1:0] != 2'b00);
            default:     req_err = 1'b1;
        endcase
        if (write_q && ((funct3_q == F3_BU) || (funct3_q == F3_HU))) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = wdata_q;
        case (funct3_q)
            F3_B: begin
                lane_we    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                lane_we    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            F3_W: begin
                lane_we    = 4'b1111;
                lane_wdata = wdata_q;
            end
            default: begin
                lane_we    = 4'b0000;
                lane_wdata = wdata_q;
            end
        endcase
        if (!write_q || req_err || !access) begin
            lane_we = 4'b0000;
        end
    end

    // One byte-wide array per lane so partial stores need no read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[word_idx] <= lane_wdata[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
        end
    endgenerate

    assign sel_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    assign sel_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'h0;
        case (funct3_q)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0, sel_half};
            F3_W:    load_data = rd_word;
            default: load_data = 32'h0;
        endcase
        if (write_q || req_err) begin
            load_data = 32'h0;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    cnt_d    = LAT_INIT;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (access) begin
                    cnt_d        = 4'd0;
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                    resp_err_d   = req_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 8'h0;
            wdata_q      <= 32'h0;
            funct3_q     <= 3'b000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed-vector bench: stimulus pushes expected responses, a negedge monitor pops them on handshakes.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = 8'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'b010;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    logic        req_valid2 = 1'b0;
    logic        req_ready2;
    logic        resp_valid2;
    logic        resp_ready2 = 1'b1;
    logic [31:0] resp_rdata2;
    logic        resp_err2;
    logic        busy2;
    logic        req_write2 = 1'b0;
    logic [7:0]  req_addr2 = 8'h0;
    logic [31:0] req_wdata2 = 32'h0;
    logic [2:0]  req_funct3_2 = 3'b010;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb_q [$];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
        .req_addr(req_addr2), .req_wdata(req_wdata2), .req_funct3(req_funct3_2),
        .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_rdata(resp_rdata2),
        .resp_err(resp_err2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Scoreboard monitor: one pop per completed response handshake.
    always @(negedge clk) begin
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp got=%h/%b want=none", resp_rdata, resp_err);
            end else begin
                logic [32:0] exp;
                exp = sb_q.pop_front();
                $display("resp rdata=%h err=%b exp_rdata=%h exp_err=%b", resp_rdata, resp_err, exp[31:0], exp[32]);
                chk("resp_rdata", resp_rdata, exp[31:0]);
                chk("resp_err", {31'h0, resp_err}, {31'h0, exp[32]});
            end
        end
    end

    task automatic do_req(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [2:0] f,
                          input logic [31:0] er, input bit ee, input int hold);
        int k;
        int lat;
        resp_ready = (hold == 0);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_funct3 = f;
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("req_ready_wait", {31'h0, req_ready}, 32'h1);
        sb_q.push_back({ee, er});
        @(posedge clk); #1;
        // Junk on the request bus after accept must be ignored.
        req_valid  = 1'b0;
        req_write  = ~w;
        req_addr   = 8'hFF;
        req_wdata  = 32'hA5A5A5A5;
        req_funct3 = 3'b111;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT));
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", {31'h0, resp_valid}, 32'h1);
            chk("hold_rdata", resp_rdata, er);
            chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_valid", {31'h0, resp_valid}, 32'h0);
        chk("post_hs_ready", {31'h0, req_ready}, 32'h1);
        $display("req w=%b addr=%h wdata=%h f3=%b lat=%0d hold=%0d", w, a, d, f, lat, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc [$];
        #2;
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_req_ready", {31'h0, req_ready}, 32'h1);

        do_req(1, 8'h10, 32'hDEADBEEF, 3'b010, 32'h0,        0, 0);
        do_req(0, 8'h10, 32'h0,        3'b010, 32'hDEADBEEF, 0, 0);
        do_req(1, 8'h11, 32'h00000080, 3'b000, 32'h0,        0, 0);
        do_req(0, 8'h10, 32'h0,        3'b010, 32'hDEAD80EF, 0, 0);
        do_req(0, 8'h11, 32'h0,        3'b000, 32'hFFFFFF80, 0, 0);
        do_req(0, 8'h11, 32'h0,        3'b100, 32'h00000080, 0, 0);
        do_req(0, 8'h12, 32'h0,        3'b101, 32'h0000DEAD, 0, 0);
        do_req(0, 8'h12, 32'h0,        3'b001, 32'hFFFFDEAD, 0, 0);
        do_req(0, 8'h10, 32'h0,        3'b000, 32'hFFFFFFEF, 0, 0);
        do_req(0, 8'h06, 32'h0,        3'b010, 32'h0,        1, 0);
        do_req(1, 8'h13, 32'h0000BEEF, 3'b001, 32'h0,        1, 0);
        do_req(1, 8'h10, 32'h00000011, 3'b100, 32'h0,        1, 0);
        do_req(0, 8'h10, 32'h0,        3'b011, 32'h0,        1, 0);
        do_req(0, 8'h10, 32'h0,        3'b010, 32'hDEAD80EF, 0, 0);
        do_req(1, 8'h12, 32'hFFFF1234, 3'b001, 32'h0,        0, 0);
        do_req(0, 8'h10, 32'h0,        3'b010, 32'h123480EF, 0, 5);

        // Store aborted by reset mid-WAIT must leave the old word in place.
        do_req(1, 8'h20, 32'hCAFEF00D, 3'b010, 32'h0, 0, 0);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 8'h20;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        #1;
        chk("async_rst_busy", {31'h0, busy}, 32'h0);
        chk("async_rst_valid", {31'h0, resp_valid}, 32'h0);
        chk("async_rst_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rel2_req_ready", {31'h0, req_ready}, 32'h1);
        do_req(0, 8'h20, 32'h0, 3'b010, 32'hCAFEF00D, 0, 0);

        // LATENCY=1 instance with req_valid stuck high: accepts every 3 cycles.
        req_valid2 = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (req_ready2 === 1'b1) acc_cyc.push_back(c);
            @(posedge clk); #1;
        end
        req_valid2 = 1'b0;
        chk("l1_accept_count", 32'(acc_cyc.size()), 32'd5);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            chk("l1_accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        end
        $display("l1 accepts=%0d", acc_cyc.size());

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
